// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx serializer between N_REQ byte producers. Requesters are
//   arbitrated round-robin. The winning byte goes to the serializer with a
//   one-cycle tx_start, and the block then waits for tx_done_tick before it
//   arbitrates again. Every output comes from a register.
//
// Optional feature: define UART_TX_ARB_LOCK_EN to enable message lock. With the
//   lock enabled, a byte sent with req_last=0 keeps the serializer reserved for
//   the same requester until a byte with req_last=1 has been sent.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   req_valid     in   [N_REQ]   per-requester byte valid
//   req_data      in   [8*N_REQ] byte of requester i in bits [8i+7:8i]
//   req_last      in   [N_REQ]   final byte of a message (lock build only)
//   req_ready     out  [N_REQ]   one-cycle one-hot acceptance pulse
//   grant         out  [N_REQ]   one-hot owner of the serializer
//   busy          out            high whenever the FSM is not idle
//   tx_start      out            one-cycle start pulse to uart_tx
//   tx_din        out  [8]      byte to uart_tx
//   tx_done_tick  in             completion pulse from uart_tx
module uart_tx_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               tx_start,
    output logic [7:0]         tx_din,
    input  logic               tx_done_tick
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t           state_r;
    logic [PW-1:0]    ptr_r;
    logic [N_REQ-1:0] eligible_s;
    logic             found_s;
    logic [PW-1:0]    win_s;
    logic [N_REQ-1:0] win_onehot_s;
    logic [7:0]       win_data_s;
    int               dist_s;
    int               best_s;

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_r;
    logic last_q_r;
    logic win_last_s;

    // Eligible set: while a message is locked, only its owner may compete.
    always_comb begin
        if (lock_r) begin
            eligible_s = req_valid & ({{(N_REQ-1){1'b0}}, 1'b1} << ptr_r);
        end else begin
            eligible_s = req_valid;
        end
    end

    // Select the req_last flag of the winning requester.
    always_comb begin
        win_last_s = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (PW'(j) == win_s) begin
                win_last_s = req_last[j];
            end else begin
                win_last_s = win_last_s;
            end
        end
    end
`else
    logic unused_last_s;
    assign unused_last_s = ^req_last;

    // Eligible set: every valid requester competes for every byte.
    always_comb begin
        eligible_s = req_valid;
    end
`endif

    // Round-robin pick: smallest distance after ptr_r, so ptr_r itself is considered last.
    always_comb begin
        found_s = 1'b0;
        win_s   = ptr_r;
        best_s  = N_REQ;
        dist_s  = 32'sd0;
        for (int j = 0; j < N_REQ; j++) begin
            dist_s = j - int'(ptr_r) - 32'sd1;
            if (dist_s < 32'sd0) begin
                dist_s = dist_s + N_REQ;
            end else begin
                dist_s = dist_s;
            end
            if (eligible_s[j] && (dist_s < best_s)) begin
                best_s  = dist_s;
                found_s = 1'b1;
                win_s   = PW'(j);
            end else begin
                best_s  = best_s;
            end
        end
        win_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
    end

    // Select the byte of the winning requester.
    always_comb begin
        win_data_s = 8'h00;
        for (int j = 0; j < N_REQ; j++) begin
            if (PW'(j) == win_s) begin
                win_data_s = req_data[8*j +: 8];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            ptr_r     <= PW'(N_REQ - 1);
            grant     <= '0;
            req_ready <= '0;
            busy      <= 1'b0;
            tx_start  <= 1'b0;
            tx_din    <= 8'h00;
`ifdef UART_TX_ARB_LOCK_EN
            lock_r    <= 1'b0;
            last_q_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        state_r   <= ST_START;
                        ptr_r     <= win_s;
                        grant     <= win_onehot_s;
                        req_ready <= win_onehot_s;
                        tx_start  <= 1'b1;
                        busy      <= 1'b1;
                        tx_din    <= win_data_s;
`ifdef UART_TX_ARB_LOCK_EN
                        last_q_r  <= win_last_s;
`endif
                    end else begin
                        grant     <= '0;
                        req_ready <= '0;
                        tx_start  <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                ST_START: begin
                    // The byte is accepted in this cycle, so the lock follows its last flag.
                    state_r   <= ST_WAIT;
                    tx_start  <= 1'b0;
                    req_ready <= '0;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_r    <= ~last_q_r;
`endif
                end
                ST_WAIT: begin
                    if (tx_done_tick) begin
                        state_r <= ST_IDLE;
                        grant   <= '0;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    grant     <= '0;
                    req_ready <= '0;
                    tx_start  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. It drives the requesters from per-requester
// byte queues and imitates uart_tx with a configurable frame latency. A
// transaction-level model predicts the outputs on every cycle. Directed
// scenarios also check literal expectations for grant order and timing.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           tx_start;
    logic [7:0]     tx_din;
    logic           tx_done_tick;

    uart_tx_arbiter #(.N_REQ(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant        (grant),
        .busy         (busy),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         gap;
    } item_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Requester side: a byte queue and an inter-byte gap counter per requester.
    item_t rq [N][$];
    int    gap_cnt [N];

    // uart_tx imitation.
    int u_cnt = 0;
    int u_lat = 3;
    bit u_rand = 1'b0;
    bit stray_start_en = 1'b0;
    bit stray_idle_rand = 1'b0;

    // Transaction-level model: current owner (-1 when idle) and cycles since its start.
    int         m_cur = -1;
    int         m_age = 0;
    int         m_ptr = N - 1;
    int         m_lock = -1;
    logic [7:0] m_din = 8'h00;
    logic       m_plast = 1'b0;

    // Event logs for the directed scenarios.
    int         st_who[$];
    int         st_cyc[$];
    logic [7:0] st_din[$];
    logic [N-1:0] st_ready[$];
    logic [N-1:0] st_grant[$];
    int         done_cyc[$];
    int         busy_fall[$];
    logic       busy_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        st_who.delete(); st_cyc.delete(); st_din.delete();
        st_ready.delete(); st_grant.delete(); done_cyc.delete(); busy_fall.delete();
    endtask

    // One clock cycle: check outputs, react to them, drive inputs, step the model.
    task automatic tick(input bit rst_now, input bit stray_now);
        logic [N-1:0]   e_grant;
        logic [N-1:0]   e_ready;
        logic           e_start;
        logic           e_busy;
        logic [N-1:0]   v;
        logic [8*N-1:0] d;
        logic [N-1:0]   l;
        logic [N-1:0]   elig;
        logic           done;
        int             who;
        int             idx;
        @(negedge clk);
        e_busy  = (m_cur >= 0);
        e_grant = '0;
        if (m_cur >= 0) e_grant[m_cur] = 1'b1;
        e_start = (m_cur >= 0) && (m_age == 0);
        e_ready = e_start ? e_grant : '0;
        if (chk_en) begin
            check("busy", 32'(busy), 32'(e_busy));
            check("grant", 32'(grant), 32'(e_grant));
            check("tx_start", 32'(tx_start), 32'(e_start));
            check("req_ready", 32'(req_ready), 32'(e_ready));
            check("tx_din", 32'(tx_din), 32'(m_din));
        end
        if (busy_prev === 1'b1 && busy === 1'b0) busy_fall.push_back(cyc);
        busy_prev = busy;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] === 1'b1 && rq[i].size() > 0) begin
                gap_cnt[i] = rq[i][0].gap;
                void'(rq[i].pop_front());
            end
        end
        done = 1'b0;
        if (tx_start === 1'b1) begin
            who = -1;
            for (int i = 0; i < N; i++) if (grant[i] === 1'b1) who = i;
            st_who.push_back(who); st_cyc.push_back(cyc); st_din.push_back(tx_din);
            st_ready.push_back(req_ready); st_grant.push_back(grant);
            u_cnt = (u_rand ? $urandom_range(6, 1) : u_lat) + 1;
            if (stray_start_en) done = 1'b1;
        end
        if (u_cnt > 0) begin
            u_cnt--;
            if (u_cnt == 0) begin
                done = 1'b1;
                done_cyc.push_back(cyc);
            end
        end else if (stray_idle_rand && $urandom_range(7, 0) == 0) begin
            done = 1'b1;
        end
        if (stray_now) done = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (gap_cnt[i] > 0) begin
                gap_cnt[i]--;
                v[i] = 1'b0;
            end else begin
                v[i] = (rq[i].size() > 0);
            end
            d[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0].d : 8'($urandom);
            l[i]        = (rq[i].size() > 0) ? rq[i][0].l : 1'b0;
        end
        if (rst_now) u_cnt = 0;
        reset = rst_now; req_valid = v; req_data = d; req_last = l; tx_done_tick = done;
        // Model step for the coming clock edge.
        if (rst_now) begin
            m_cur = -1; m_age = 0; m_ptr = N - 1; m_din = 8'h00; m_lock = -1;
        end else if (m_cur < 0) begin
            elig = v;
            if (m_lock >= 0) elig = v & (N'(1) << m_lock);
            for (int k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                if (m_cur < 0 && elig[idx]) begin
                    m_cur = idx; m_age = 0; m_ptr = idx;
                    m_din = d[8*idx +: 8]; m_plast = l[idx];
                end
            end
        end else if (m_age == 0) begin
            m_age = 1;
`ifdef UART_TX_ARB_LOCK_EN
            m_lock = m_plast ? -1 : m_cur;
`endif
        end else if (done) begin
            m_cur = -1;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic push(input int r, input logic [7:0] dd, input logic ll, input int gg);
        item_t it;
        it.d = dd; it.l = ll; it.gap = gg;
        rq[r].push_back(it);
    endtask

    task automatic check_order(input string name, input int exp_who[$]);
        check({name, "_count"}, 32'(st_who.size()), 32'(exp_who.size()));
        for (int k = 0; k < exp_who.size(); k++) begin
            check({name, "_who"}, (k < st_who.size()) ? 32'(st_who[k]) : 32'hFFFF_FFFF, 32'(exp_who[k]));
        end
    endtask

    task automatic check_turnaround(input string name);
        for (int k = 1; k < st_cyc.size(); k++) begin
            check({name, "_gap"}, 32'(st_cyc[k]),
                  (k - 1 < done_cyc.size()) ? 32'(done_cyc[k-1] + 2) : 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        int t_req;
        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done_tick = 1'b0;
        for (int i = 0; i < N; i++) gap_cnt[i] = 0;

        // Reset values.
        tick(1'b1, 1'b0);
        chk_en = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_tx_din", 32'(tx_din), 32'h00);

        // Single requester 1 with byte A5.
        clear_logs(); u_lat = 3;
        push(1, 8'hA5, 1'b1, 0);
        t_req = cyc;
        run(12);
        check("single_count", 32'(st_cyc.size()), 32'd1);
        if (st_cyc.size() > 0) begin
            check("single_latency", 32'(st_cyc[0]), 32'(t_req + 1));
            check("single_din", 32'(st_din[0]), 32'hA5);
            check("single_ready", 32'(st_ready[0]), 32'b0010);
            check("single_grant", 32'(st_grant[0]), 32'b0010);
        end
        check("single_busy_fall", (busy_fall.size() > 0) ? 32'(busy_fall[0]) : 32'hFFFF_FFFF,
              (done_cyc.size() > 0) ? 32'(done_cyc[0] + 1) : 32'hFFFF_FFFE);

        // All four requesters valid: order 0,1,2,3,0,1,2,3 with 2-cycle turnaround.
        tick(1'b1, 1'b0);
        clear_logs();
        for (int r = 0; r < N; r++) begin
            push(r, 8'(8'h10 + r), 1'b1, 0);
            push(r, 8'(8'h20 + r), 1'b1, 0);
        end
        run(80);
        check_order("rr4", '{0, 1, 2, 3, 0, 1, 2, 3});
        check_turnaround("rr4");

        // Holes: requesters 1 and 3 only.
        tick(1'b1, 1'b0);
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            push(1, 8'(8'h31 + k), 1'b1, 0);
            push(3, 8'(8'h41 + k), 1'b1, 0);
        end
        run(60);
        check_order("holes", '{1, 3, 1, 3, 1, 3});
        check_turnaround("holes");

        // Stray tx_done_tick in IDLE and during START is ignored.
        tick(1'b1, 1'b0);
        clear_logs(); u_lat = 4;
        tick(1'b0, 1'b1);
        push(0, 8'h5C, 1'b1, 0);
        stray_start_en = 1'b1;
        run(15);
        stray_start_en = 1'b0;
        check("stray_starts", 32'(st_cyc.size()), 32'd1);
        check("stray_busy_fall", (busy_fall.size() > 0) ? 32'(busy_fall[0]) : 32'hFFFF_FFFF,
              (done_cyc.size() > 0) ? 32'(done_cyc[0] + 1) : 32'hFFFF_FFFE);

        // Three-byte message from requester 2 with a gap; requester 0 competes.
        tick(1'b1, 1'b0);
        clear_logs(); u_lat = 3;
        push(2, 8'h71, 1'b0, 10);
        push(2, 8'h72, 1'b0, 0);
        push(2, 8'h73, 1'b1, 0);
        tick(1'b0, 1'b0);
        push(0, 8'h44, 1'b1, 0);
        run(80);
`ifdef UART_TX_ARB_LOCK_EN
        check_order("lock", '{2, 2, 2, 0});
`else
        check_order("nolock", '{2, 0, 2, 2});
`endif

        // Reset while waiting for the serializer.
        tick(1'b1, 1'b0);
        clear_logs(); u_lat = 6;
        push(0, 8'h01, 1'b1, 0);
        push(0, 8'h02, 1'b1, 0);
        push(1, 8'h11, 1'b1, 0);
        run(4);
        check("wait_busy", 32'(busy), 32'd1);
        tick(1'b1, 1'b0);
        clear_logs();
        tick(1'b0, 1'b0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_tx_start", 32'(tx_start), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_tx_din", 32'(tx_din), 32'h00);
        run(40);
        check("mid_rst_first", (st_who.size() > 0) ? 32'(st_who[0]) : 32'hFFFF_FFFF, 32'd0);

        // Randomized traffic with random latency, stray ticks and occasional reset.
        u_rand = 1'b1; stray_idle_rand = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < N; r++) begin
                if (rq[r].size() < 3 && $urandom_range(3, 0) == 0)
                    push(r, 8'($urandom), 1'($urandom_range(1, 0)), int'($urandom_range(4, 0)));
            end
            stray_start_en = ($urandom_range(3, 0) == 0);
            tick($urandom_range(199, 0) == 0, 1'b0);
        end
        stray_start_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
